// File: rtl/comp_fetch_ctrl_pkg.sv
// Shared definitions for the compressed-code fetch controller: state encodings,
// field-slot geometry and constant helpers for per-field offsets.
package comp_defs;

  localparam int MAX_FIELDS = 4;
  localparam int SLOT_W     = 8;
  localparam int SLOTS_W    = MAX_FIELDS * SLOT_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_RESOLVE  = 3'd2,
    S_DECOMP   = 3'd3,
    S_MEM      = 3'd4,
    S_CLASSIFY = 3'd5,
    S_RESPOND  = 3'd6
  } fetch_state_e;

  typedef enum logic [1:0] {
    FILL_NONE = 2'd0,
    FILL_RAW  = 2'd1,
    FILL_COMP = 2'd2
  } fill_kind_e;

  function automatic int slot_width(input logic [SLOTS_W-1:0] slots, input int idx);
    return int'(slots[idx*SLOT_W +: SLOT_W]);
  endfunction

  // Bit offset of field idx: sum of all lower slots. idx == MAX_FIELDS gives the total.
  function automatic int slot_offset(input logic [SLOTS_W-1:0] slots, input int idx);
    int off;
    off = 0;
    for (int i = 0; i < MAX_FIELDS; i++) begin
      if (i < idx) off += slot_width(slots, i);
    end
    return off;
  endfunction

  function automatic int key_total(input logic [SLOTS_W-1:0] key_slots);
    return slot_offset(key_slots, MAX_FIELDS);
  endfunction

endpackage

// File: rtl/comp_fetch_ctrl_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/comp_fetch_ctrl.sv
// Instruction-fetch controller: looks up raw and compressed icaches, decompresses
// through per-field dictionaries on a compressed hit, and fetches/classifies/fills on a miss.
//
// state      | meaning
// S_IDLE     | waiting for proc_valid; latches the fetch address
// S_LOOKUP   | one-cycle lookup request to both caches
// S_RESOLVE  | sample cache results and pick hit path
// S_DECOMP   | dictionaries translate keys back into the word
// S_MEM      | external memory request held until accepted
// S_CLASSIFY | try per-field compression and choose the fill target
// S_RESPOND  | proc_ready (if still requested) and the fill pulse
module comp_fetch_ctrl
  import comp_defs::*;
#(
  parameter int                           NUM_FIELDS  = 3,
  parameter logic [SLOT_W*NUM_FIELDS-1:0] FIELD_VAL_W = {8'd10, 8'd15, 8'd7},
  parameter logic [SLOT_W*NUM_FIELDS-1:0] FIELD_KEY_W = {8'd5, 8'd8, 8'd3},
  parameter int                           CNT_W       = 16,
  localparam int                          KEY_TOTAL   = key_total(SLOTS_W'(FIELD_KEY_W))
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  proc_valid,
  output logic                  proc_ready,
  input  logic [31:0]           proc_addr,
  output logic [31:0]           proc_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [31:0]           mem_req_addr,
  input  logic [31:0]           mem_req_rdata,

  input  logic                  comp_en,

  output logic                  raw_lk_valid,
  output logic [31:0]           raw_lk_addr,
  input  logic                  raw_hit,
  input  logic [31:0]           raw_data,
  output logic                  raw_fill_valid,
  output logic [31:0]           raw_fill_addr,
  output logic [31:0]           raw_fill_data,

  output logic                  comp_lk_valid,
  output logic [31:0]           comp_lk_addr,
  input  logic                  comp_hit,
  input  logic [KEY_TOTAL-1:0]  comp_data,
  output logic                  comp_fill_valid,
  output logic [31:0]           comp_fill_addr,
  output logic [KEY_TOTAL-1:0]  comp_fill_data,

  output logic [KEY_TOTAL-1:0]  dict_key_lookup,
  input  logic [31:0]           dict_val_found,
  output logic [31:0]           dict_val_lookup,
  input  logic [KEY_TOTAL-1:0]  dict_key_found,
  input  logic [NUM_FIELDS-1:0] dict_val_hit,

  output logic [CNT_W-1:0]      cnt_comp_hit,
  output logic [CNT_W-1:0]      cnt_raw_hit,
  output logic [CNT_W-1:0]      cnt_miss,
  output logic [CNT_W-1:0]      cnt_incomp,
  output logic                  err_dual_hit
);

  localparam logic [SLOTS_W-1:0] VAL_SLOTS = SLOTS_W'(FIELD_VAL_W);
  localparam logic [SLOTS_W-1:0] KEY_SLOTS = SLOTS_W'(FIELD_KEY_W);

  fetch_state_e state_q, state_d;
  fill_kind_e   fill_kind_q;

  logic [31:0]          addr_q;
  logic [31:0]          word_q;
  logic [KEY_TOTAL-1:0] fill_key_q;
  logic                 comp_en_q;
  logic                 raw_hit_q;

  logic [31:0]          dec_word;
  logic [KEY_TOTAL-1:0] enc_key;
  logic                 all_fields_hit;
  logic                 compressible;

  logic inc_comp_hit, inc_raw_hit, inc_miss, inc_incomp;

  // Rebuild the word and key field by field so only declared field bits propagate.
  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    localparam int VO = slot_offset(VAL_SLOTS, f);
    localparam int VW = slot_width(VAL_SLOTS, f);
    localparam int KO = slot_offset(KEY_SLOTS, f);
    localparam int KW = slot_width(KEY_SLOTS, f);
    assign dec_word[VO +: VW] = dict_val_found[VO +: VW];
    assign enc_key[KO +: KW]  = dict_key_found[KO +: KW];
  end

  assign all_fields_hit = &dict_val_hit;
  assign compressible   = comp_en && all_fields_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    proc_ready      = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    raw_lk_valid    = 1'b0;
    raw_lk_addr     = '0;
    comp_lk_valid   = 1'b0;
    comp_lk_addr    = '0;
    raw_fill_valid  = 1'b0;
    raw_fill_addr   = '0;
    raw_fill_data   = '0;
    comp_fill_valid = 1'b0;
    comp_fill_addr  = '0;
    comp_fill_data  = '0;
    dict_val_lookup = '0;
    inc_comp_hit    = 1'b0;
    inc_raw_hit     = 1'b0;
    inc_miss        = 1'b0;
    inc_incomp      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (proc_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        raw_lk_valid  = 1'b1;
        raw_lk_addr   = addr_q;
        comp_lk_valid = comp_en;
        comp_lk_addr  = comp_en ? addr_q : '0;
        state_d       = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (comp_en_q && comp_hit) state_d = S_DECOMP;
        else if (raw_hit)          state_d = S_RESPOND;
        else                       state_d = S_MEM;
      end
      S_DECOMP: begin
        inc_comp_hit = 1'b1;
        state_d      = S_RESPOND;
      end
      S_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) begin
          inc_miss = 1'b1;
          state_d  = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        dict_val_lookup = word_q;
        inc_incomp      = !compressible;
        state_d         = S_RESPOND;
      end
      S_RESPOND: begin
        proc_ready  = proc_valid;
        inc_raw_hit = raw_hit_q;
        if (fill_kind_q == FILL_RAW) begin
          raw_fill_valid = 1'b1;
          raw_fill_addr  = addr_q;
          raw_fill_data  = word_q;
        end
        if (fill_kind_q == FILL_COMP) begin
          comp_fill_valid = 1'b1;
          comp_fill_addr  = addr_q;
          comp_fill_data  = fill_key_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q          <= '0;
      word_q          <= '0;
      fill_key_q      <= '0;
      fill_kind_q     <= FILL_NONE;
      comp_en_q       <= 1'b0;
      raw_hit_q       <= 1'b0;
      proc_rdata      <= '0;
      dict_key_lookup <= '0;
      err_dual_hit    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (proc_valid) begin
            addr_q      <= proc_addr;
            raw_hit_q   <= 1'b0;
            fill_kind_q <= FILL_NONE;
          end
        end
        S_LOOKUP: comp_en_q <= comp_en;
        S_RESOLVE: begin
          // A compressed hit takes priority; a simultaneous raw hit is flagged.
          if (comp_en_q && comp_hit) begin
            dict_key_lookup <= comp_data;
            if (raw_hit) err_dual_hit <= 1'b1;
          end else if (raw_hit) begin
            proc_rdata <= raw_data;
            raw_hit_q  <= 1'b1;
          end
        end
        S_DECOMP: proc_rdata <= dec_word;
        S_MEM: begin
          if (mem_req_ready) word_q <= mem_req_rdata;
        end
        S_CLASSIFY: begin
          proc_rdata <= word_q;
          if (compressible) begin
            fill_kind_q <= FILL_COMP;
            fill_key_q  <= enc_key;
          end else begin
            fill_kind_q <= FILL_RAW;
          end
        end
        S_RESPOND: fill_kind_q <= FILL_NONE;
        default: ;
      endcase
    end
  end

  sat_cnt #(.CNT_W(CNT_W)) u_cnt_comp_hit (
    .clk(clk), .resetn(resetn), .inc(inc_comp_hit), .cnt(cnt_comp_hit)
  );
  sat_cnt #(.CNT_W(CNT_W)) u_cnt_raw_hit (
    .clk(clk), .resetn(resetn), .inc(inc_raw_hit), .cnt(cnt_raw_hit)
  );
  sat_cnt #(.CNT_W(CNT_W)) u_cnt_miss (
    .clk(clk), .resetn(resetn), .inc(inc_miss), .cnt(cnt_miss)
  );
  sat_cnt #(.CNT_W(CNT_W)) u_cnt_incomp (
    .clk(clk), .resetn(resetn), .inc(inc_incomp), .cnt(cnt_incomp)
  );

endmodule
